// File: rtl/wb_writer_pkg.sv
// Shared types for the write-back sequencer: widths, FSM state encoding and queue entry.
package wb_writer_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_writer_if.sv
// Bus bundle between MEM/WB, the write-back sequencer, the register-file write port and decode.
interface wb_writer_if import wb_writer_pkg::*; #(
    parameter int DEPTH = 2
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    // MEM/WB handshake: a result transfers at a rising edge where wb_valid && wb_ready.
    logic                  tick_tock;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  wb_ready;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] writereg_addr;
    logic [XLEN-1:0]       writedata;
    logic [CW-1:0]         pending;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_fwd_hit;
    logic                  rs2_fwd_hit;
    logic [XLEN-1:0]       rs1_fwd_data;
    logic [XLEN-1:0]       rs2_fwd_data;

    modport slave (
        input  tick_tock, wb_valid, wb_rd_addr, wb_data, rs1_addr, rs2_addr,
        output wb_ready, regwrite, writereg_addr, writedata, pending,
        output rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data
    );

    modport master (
        output tick_tock, wb_valid, wb_rd_addr, wb_data, rs1_addr, rs2_addr,
        input  wb_ready, regwrite, writereg_addr, writedata, pending,
        input  rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data
    );

endinterface

// File: rtl/wb_queue.sv
// In-order circular queue of pending register writes; exposes every slot for bypass matching.
module wb_queue import wb_writer_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  wb_entry_t     i_entry,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic [PW-1:0] o_head,
    output wb_entry_t     o_entries [DEPTH]
);

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Caller only pushes when not full and only pops when not empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_entry;
                r_tail        <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_head;
    assign o_entries = r_mem;

endmodule

// File: rtl/wb_writer.sv
// Write-back sequencer: queues retired results and issues them on the write phase of tick_tock.
// Optional decode bypass of queued values is built when WB_BYPASS_EN is defined.
module wb_writer import wb_writer_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    wb_writer_if.slave bus,
    output wb_state_e o_dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [PW-1:0]         w_head;
    wb_entry_t             w_entries [DEPTH];
    wb_entry_t             w_in;
    wb_entry_t             w_next_entry;
    logic [PW-1:0]         w_sel_idx;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_remaining;
    logic                  w_next_nonempty;
    logic                  w_rs1_hit;
    logic                  w_rs2_hit;
    logic [XLEN-1:0]       w_rs1_data;
    logic [XLEN-1:0]       w_rs2_data;

    wb_state_e             r_state;
    logic                  r_regwrite;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]       r_data;

    // Writes to x0 are accepted on the handshake but never stored.
    assign w_push = bus.wb_valid && !w_full && (bus.wb_rd_addr != '0);
    assign w_pop  = (r_state == HOLD);

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_entry   (w_in),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count),
        .o_head    (w_head),
        .o_entries (w_entries)
    );

    // Entry that will sit at the head after this edge, including a same-edge enqueue.
    always_comb begin
        w_in.addr       = bus.wb_rd_addr;
        w_in.data       = bus.wb_data;
        w_remaining     = w_pop ? (w_count >= CW'(2)) : !w_empty;
        w_sel_idx       = w_pop ? (w_head + PW'(1)) : w_head;
        w_next_entry    = w_remaining ? w_entries[w_sel_idx] : w_in;
        w_next_nonempty = w_remaining || w_push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_regwrite <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_next_nonempty && bus.tick_tock) begin
                        r_state    <= ISSUE;
                        r_regwrite <= 1'b1;
                        r_addr     <= w_next_entry.addr;
                        r_data     <= w_next_entry.data;
                    end else begin
                        r_state    <= IDLE;
                        r_regwrite <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_state    <= HOLD;
                    r_regwrite <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_regwrite <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        w_rs1_hit  = 1'b0;
        w_rs2_hit  = 1'b0;
        w_rs1_data = '0;
        w_rs2_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = w_head + PW'(i);
            if (CW'(i) < w_count) begin
                if ((bus.rs1_addr != '0) && (w_entries[w_idx].addr == bus.rs1_addr)) begin
                    w_rs1_hit  = 1'b1;
                    w_rs1_data = w_entries[w_idx].data;
                end
                if ((bus.rs2_addr != '0) && (w_entries[w_idx].addr == bus.rs2_addr)) begin
                    w_rs2_hit  = 1'b1;
                    w_rs2_data = w_entries[w_idx].data;
                end
            end
        end
    end
`else
    logic w_unused_rs;
    assign w_unused_rs = ^{bus.rs1_addr, bus.rs2_addr};
    assign w_rs1_hit   = 1'b0;
    assign w_rs2_hit   = 1'b0;
    assign w_rs1_data  = '0;
    assign w_rs2_data  = '0;
`endif

    assign bus.wb_ready      = !w_full;
    assign bus.pending       = w_count;
    assign bus.regwrite      = r_regwrite;
    assign bus.writereg_addr = r_addr;
    assign bus.writedata     = r_data;
    assign bus.rs1_fwd_hit   = w_rs1_hit;
    assign bus.rs2_fwd_hit   = w_rs2_hit;
    assign bus.rs1_fwd_data  = w_rs1_data;
    assign bus.rs2_fwd_data  = w_rs2_data;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: queue-level reference model checked every cycle, directed scenarios, random traffic.
module tb_wb_writer;
    import wb_writer_pkg::*;

    localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    wb_state_e dbg_state;

    wb_writer_if #(.DEPTH(DEPTH)) bus ();

    wb_writer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {addr,data}; a commit occupies two cycles and
    // may only start at an edge where tick_tock is 1.
    logic [36:0] mq [$];
    int          m_busy = 0;
    logic        m_rw = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    bit          m_live = 1'b0;

    always @(posedge clk) begin : model
        bit rdy;
        cyc++;
        if (rst) begin
            mq.delete();
            m_busy = 0;
            m_rw   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            rdy = (mq.size() < DEPTH);
            if (m_busy == 1) void'(mq.pop_front());
            if (bus.wb_valid && rdy && bus.wb_rd_addr != 5'd0)
                mq.push_back({bus.wb_rd_addr, bus.wb_data});
            if (m_busy != 2 && bus.tick_tock && mq.size() > 0) begin
                m_rw   = 1'b1;
                m_wa   = mq[0][36:32];
                m_wd   = mq[0][31:0];
                m_busy = 2;
            end else begin
                m_rw   = 1'b0;
                m_busy = (m_busy == 2) ? 1 : 0;
            end
        end
    end

    function automatic void fwd(input logic [4:0] ra, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (BYP && ra != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i][36:32] == ra) begin
                    hit = 1'b1;
                    d   = mq[i][31:0];
                end
            end
        end
    endfunction

    logic [4:0] c_addr [$];
    int         c_cyc  [$];

    always @(negedge clk) begin : compare
        logic        h;
        logic [31:0] d;
        if (m_live) begin
            check("regwrite", 32'(bus.regwrite), 32'(m_rw));
            check("writereg_addr", 32'(bus.writereg_addr), 32'(m_wa));
            check("writedata", bus.writedata, m_wd);
            check("pending", 32'(bus.pending), 32'(mq.size()));
            check("wb_ready", 32'(bus.wb_ready), 32'(mq.size() < DEPTH));
            fwd(bus.rs1_addr, h, d);
            check("rs1_fwd_hit", 32'(bus.rs1_fwd_hit), 32'(h));
            check("rs1_fwd_data", bus.rs1_fwd_data, d);
            fwd(bus.rs2_addr, h, d);
            check("rs2_fwd_hit", 32'(bus.rs2_fwd_hit), 32'(h));
            check("rs2_fwd_data", bus.rs2_fwd_data, d);
            if (bus.regwrite) begin
                c_addr.push_back(bus.writereg_addr);
                c_cyc.push_back(cyc);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.tick_tock = ~bus.tick_tock;
    endtask

    task automatic align_tick_high();
        if (!bus.tick_tock) next_cycle();
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        bit acc;
        int n;
        n = 0;
        bus.wb_valid   = 1'b1;
        bus.wb_rd_addr = a;
        bus.wb_data    = d;
        do begin
            acc = bus.wb_ready;
            next_cycle();
            n++;
        end while (!acc && n < 20);
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: rd=%0d not accepted within 20 cycles", a);
        end
        bus.wb_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_regwrite"}, 32'(bus.regwrite), 32'd0);
        check({tag, "_addr"}, 32'(bus.writereg_addr), 32'd0);
        check({tag, "_data"}, bus.writedata, 32'd0);
        check({tag, "_pending"}, 32'(bus.pending), 32'd0);
        check({tag, "_ready"}, 32'(bus.wb_ready), 32'd1);
        check({tag, "_rs1_hit"}, 32'(bus.rs1_fwd_hit), 32'd0);
        check({tag, "_rs1_data"}, bus.rs1_fwd_data, 32'd0);
    endtask

    initial begin
        bus.tick_tock  = 1'b0;
        bus.wb_valid   = 1'b0;
        bus.wb_rd_addr = '0;
        bus.wb_data    = '0;
        bus.rs1_addr   = '0;
        bus.rs2_addr   = '0;
        repeat (3) next_cycle();
        rst = 1'b0;
        check_reset_values("reset");

        // Single write presented in a read-phase cycle
        align_tick_high();
        push(5'd5, 32'hDEADBEEF);
        check("t1_regwrite", 32'(bus.regwrite), 32'd1);
        check("t1_addr", 32'(bus.writereg_addr), 32'd5);
        check("t1_data", bus.writedata, 32'hDEADBEEF);
        next_cycle();
        check("t1_hold_regwrite", 32'(bus.regwrite), 32'd0);
        check("t1_hold_addr", 32'(bus.writereg_addr), 32'd5);
        check("t1_hold_data", bus.writedata, 32'hDEADBEEF);
        check("t1_hold_pending", 32'(bus.pending), 32'd1);
        next_cycle();
        check("t1_done_pending", 32'(bus.pending), 32'd0);
        check("t1_done_regwrite", 32'(bus.regwrite), 32'd0);

        // Write to x0 is swallowed
        push(5'd0, 32'h1234);
        for (int i = 0; i < 4; i++) begin
            check("t2_pending", 32'(bus.pending), 32'd0);
            check("t2_regwrite", 32'(bus.regwrite), 32'd0);
            next_cycle();
        end

        // Back-to-back writes overflow a 2-deep queue
        c_addr.delete();
        c_cyc.delete();
        align_tick_high();
        push(5'd1, 32'h11);
        push(5'd2, 32'h22);
        check("t3_full_ready", 32'(bus.wb_ready), 32'd0);
        check("t3_full_pending", 32'(bus.pending), 32'd2);
        push(5'd3, 32'h33);
        repeat (6) next_cycle();
        check("t3_commit_count", 32'(c_addr.size()), 32'd3);
        if (c_addr.size() == 3) begin
            check("t3_order0", 32'(c_addr[0]), 32'd1);
            check("t3_order1", 32'(c_addr[1]), 32'd2);
            check("t3_order2", 32'(c_addr[2]), 32'd3);
            check("t3_spacing01", 32'(c_cyc[1] - c_cyc[0]), 32'd2);
            check("t3_spacing12", 32'(c_cyc[2] - c_cyc[1]), 32'd2);
        end

        // Same register twice: bypass returns the youngest value
        bus.rs1_addr = 5'd7;
        align_tick_high();
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        check("t4_pending2", 32'(bus.pending), 32'd2);
        check("t4_hit2", 32'(bus.rs1_fwd_hit), BYP ? 32'd1 : 32'd0);
        check("t4_data2", bus.rs1_fwd_data, BYP ? 32'hB : 32'h0);
        next_cycle();
        check("t4_pending1", 32'(bus.pending), 32'd1);
        check("t4_hit1", 32'(bus.rs1_fwd_hit), BYP ? 32'd1 : 32'd0);
        check("t4_data1", bus.rs1_fwd_data, BYP ? 32'hB : 32'h0);
        bus.rs1_addr = 5'd0;
        #1;
        check("t4_x0_hit", 32'(bus.rs1_fwd_hit), 32'd0);
        check("t4_x0_data", bus.rs1_fwd_data, 32'd0);
        repeat (4) next_cycle();

        // Reset while a write is in HOLD with another queued behind it
        align_tick_high();
        push(5'd9, 32'h55);
        push(5'd10, 32'h66);
        check("t5_in_hold_pending", 32'(bus.pending), 32'd2);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check_reset_values("t5");
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            check("t5_no_regwrite", 32'(bus.regwrite), 32'd0);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.wb_valid   = ($urandom_range(0, 99) < 60);
            bus.wb_rd_addr = 5'($urandom_range(0, 7));
            bus.wb_data    = $urandom;
            bus.rs1_addr   = 5'($urandom_range(0, 7));
            bus.rs2_addr   = 5'($urandom_range(0, 7));
            rst            = ($urandom_range(0, 199) == 0);
            next_cycle();
        end
        rst          = 1'b0;
        bus.wb_valid = 1'b0;
        repeat (6) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_writer.md
# wb_writer

Write-back sequencer for the pipelined RISC-V core: the writer-side counterpart of the register file. It accepts retired results from the MEM/WB stage and buffers them in a small in-order queue. It drives the register file's write port, issuing each write only in the write phase of the two-phase `tick_tock` scheme and holding address and data stable for the register file's registered load strobe. An optional bypass returns queued, not-yet-committed values to the decode-stage read ports.

## Interface
- `DEPTH`, 2, number of queue entries (power of two, ≥2)
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `tick_tock`  in  1  phase signal, toggles every cycle; 0 = write phase, 1 = read phase
- `wb_valid`  in  1  result present from MEM/WB
- `wb_rd_addr`  in  5  destination register
- `wb_data`  in  32  result value
- `wb_ready`  out  1  queue can accept (= !full)
- `regwrite`  out  1  register-file write enable
- `writereg_addr`  out  5  register-file write address
- `writedata`  out  32  register-file write data
- `pending`  out  $clog2(DEPTH)+1  number of queued entries
- `rs1_addr`, `rs2_addr`  in  5  decode read addresses (bypass)
- `rs1_fwd_hit`, `rs2_fwd_hit`  out  1  queued value available
- `rs1_fwd_data`, `rs2_fwd_data`  out  32  bypass value

## Operation
- Enqueue at the edge where `wb_valid && wb_ready`.
- A write with `wb_rd_addr == 0` is accepted and discarded: it is never stored and `pending` does not change.
- Queue order is strict FIFO. Two writes to the same register both commit, in order.
- `wb_ready` does not look ahead to a same-cycle pop. When full, `wb_ready` = 0 even if the head pops that cycle.
- FSM states:
  - IDLE: `regwrite` = 0.
  - ISSUE: `regwrite` = 1; `writereg_addr`/`writedata` = head.
  - HOLD: `regwrite` = 0; address and data still show the head.
- FSM transitions:
  - IDLE→ISSUE at an edge where the queue is non-empty and `tick_tock` = 1. ISSUE therefore always coincides with `tick_tock` = 0.
  - ISSUE→HOLD unconditionally.
  - At the end of HOLD the head is popped. Go to ISSUE if a further entry exists and `tick_tock` = 1; otherwise go to IDLE.
- An entry enqueued during HOLD counts toward that HOLD→ISSUE decision.
- If `tick_tock` is sampled 0 in ISSUE, the FSM still moves to HOLD. The register file gates writes with the phase, so this is a benign misalignment.
- In IDLE, `writereg_addr`/`writedata` hold their last values. They are 0 after reset.

## Timing
- Reset values:
  - state IDLE, queue empty
  - `pending` = 0, `wb_ready` = 1
  - `regwrite` = 0, `writereg_addr` = 0, `writedata` = 0
  - `*_fwd_hit` = 0, `*_fwd_data` = 0
- Reset mid-operation discards all queued and in-flight writes, including one in ISSUE or HOLD.
- All write-port outputs are registered.
- Minimum latency: enqueue edge → `regwrite` high is 1 cycle if `tick_tock` = 1 at the enqueue edge, otherwise 2 cycles.
- Sustained throughput is one commit per 2 cycles.
- `pending` updates at the edge. A simultaneous enqueue and pop leaves it unchanged.
- Bypass outputs are combinational from the queue contents and the read addresses.

## Configuration
- `WB_BYPASS_EN` defined: `rsN_fwd_hit` = 1 when a stored entry (including the head in ISSUE/HOLD) matches a non-zero `rsN_addr`. `rsN_fwd_data` = the youngest matching entry's data.
- `WB_BYPASS_EN` undefined: hit and data outputs are tied to 0 and the match logic is not built.

## Structure
- Shared package holds:
  - `XLEN` = 32 and `REG_ADDR_W` = 5
  - the FSM state typedef (IDLE/ISSUE/HOLD)
  - the queue entry struct {addr, data}
- One sub-module, `wb_queue`: a circular FIFO with head/tail/count, `full`/`empty` flags, and a per-entry read-out for bypass matching.
- The FSM and the bypass priority select live in `wb_writer`.

## Test plan
- Reset, then push rd=5 / 0xDEADBEEF with `tick_tock` = 1 → `regwrite` = 1 with addr 5 / data 0xDEADBEEF in the next cycle (`tick_tock` = 0), held one more cycle, `pending` returns to 0.
- Push rd=0 / 0x1234 → no `regwrite` ever and `pending` stays 0.
- With DEPTH=2, push 3 back-to-back writes (rd 1, 2, 3) → `wb_ready` drops after 2 are stored, rd3 is accepted after the first pop, and commits occur in order 1, 2, 3 spaced 2 cycles apart.
- Push rd=7 / 0xA then rd=7 / 0xB, with `rs1_addr` = 7 under `WB_BYPASS_EN` → `rs1_fwd_data` = 0xB while both are queued and 0xB after the first pops. `rs1_addr` = 0 → hit = 0.
- Assert `rst` during HOLD of a queued write → on the next cycle all outputs are at reset values and no further `regwrite` pulses occur.
- Build without `WB_BYPASS_EN` and repeat the bypass scenario → hit and data outputs stay 0, and commits are unchanged.
